path_metric_register_unit: RTL and testbench
============================================

Name: path_metric_register_unit

Overview:
- Sequential path-metric (PM) store for the 4-state Viterbi trellis.
- Closes the loop around the combinational add-compare-select unit: consumes its four new path metrics and registers them normalized, then feeds the stored metrics back as the ACSU path-metric inputs on the next trellis step.
- Also tracks the best (minimum-metric) state and counts trellis steps per frame.
- Signals end of frame to the downstream traceback stage.

Parameters:
- PM_WIDTH, 2, width of every path metric; must match the ACSU metric width.
- FRAME_LEN, 16, trellis steps per frame; range 1..(2^CNT_WIDTH - 1).
- CNT_WIDTH, 5, width of the step counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  1-cycle pulse: initialise metrics and begin a frame.
- i_valid  in  1  ACSU outputs i_PM_0..3 are valid this cycle (one trellis step).
- i_PM_0..i_PM_3  in  PM_WIDTH each  new path metrics from the ACSU.
- o_PM_0..o_PM_3  out  PM_WIDTH each  registered normalized metrics; drive the ACSU path-metric inputs.
- o_busy  out  1  high while a frame is in progress (state RUN).
- o_best_state  out  2  index of the minimum metric at the last accepted step.
- o_best_PM  out  PM_WIDTH  raw (pre-normalization) minimum at the last accepted step.
- o_step_cnt  out  CNT_WIDTH  accepted steps in the current frame.
- o_frame_done  out  1  1-cycle pulse when the frame completes.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is synchronous, active-high, and overrides all other inputs.
- Reset values: FSM=IDLE; o_PM_0=0; o_PM_1..3=all-ones (2^PM_WIDTH-1), which forces the known start state 0; o_busy=0, o_best_state=0, o_best_PM=0, o_step_cnt=0, o_frame_done=0.
- FSM states: IDLE, RUN, DONE. o_busy is registered and equals (state==RUN).
- IDLE:
  - i_valid is ignored.
  - i_start: load the init metrics (0, max, max, max), o_step_cnt<=0, go to RUN.
- RUN, i_valid=1 and i_start=0:
  - min = minimum of i_PM_0..3.
  - o_PM_k <= i_PM_k - min. Width is unchanged and no underflow is possible.
  - o_best_state <= lowest index k with i_PM_k==min (ties go to the lowest index).
  - o_best_PM <= min.
  - o_step_cnt <= o_step_cnt+1.
  - Latency: 1 cycle from i_valid to updated outputs.
- RUN, i_valid=0: all registers hold; there is no timeout.
- Frame end: the accepted step with o_step_cnt==FRAME_LEN-1 moves the FSM to DONE. In the same edge, o_frame_done<=1, o_step_cnt<=FRAME_LEN and the final metrics are registered.
- DONE:
  - Lasts exactly 1 cycle; o_frame_done deasserts on the next edge and the FSM returns to IDLE.
  - i_valid is ignored.
  - o_PM, o_best_*, o_step_cnt hold until the next i_start or reset.
- i_start in RUN or DONE restarts the frame: re-init metrics, cnt<=0, go to RUN. i_valid in the same cycle is ignored, and no o_frame_done is produced for the aborted frame.
- i_start in DONE takes priority over the return to IDLE.
- FRAME_LEN=1: the first accepted step goes straight to DONE.
- Metrics are never saturated here; the ACSU result is trusted. Normalization keeps at least one o_PM at 0 after every accepted step.

Test Plan:
- Reset held for 2 cycles with i_start=1 and i_valid=1 -> o_PM=0,3,3,3; o_busy=0; o_step_cnt=0; o_frame_done=0.
- i_start, then i_valid with i_PM=2,1,3,1 -> next edge: o_PM=1,0,2,0; o_best_state=1; o_best_PM=1; o_step_cnt=1; o_busy=1.
- In RUN, i_valid with i_PM=2,2,2,2 -> o_PM=0,0,0,0 and o_best_state=0 (tie to lowest index). The following idle cycle holds all outputs.
- FRAME_LEN=16: 16 valids with random gaps -> o_frame_done high for exactly 1 cycle, coincident with o_step_cnt=16. o_busy then drops, and a 17th i_valid changes nothing.
- i_start at o_step_cnt=5 together with i_valid -> o_PM=0,3,3,3; o_step_cnt=0; the valid is ignored; no o_frame_done. A complete 16-step frame afterwards ends normally.
- i_rst asserted mid-frame at o_step_cnt=9 -> reset values on the next edge; FSM=IDLE; subsequent i_valid is ignored until i_start.

Source files
------------

// File: rtl/path_metric_register_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : path_metric_register_unit_if
// Brief    : ACSU-facing bundle of the path-metric register unit.
// Revision : 1.0 - initial release
// ============================================================================
interface path_metric_register_unit_if #(
   parameter int PM_WIDTH  = 2,
   parameter int CNT_WIDTH = 5
);
   logic                 i_start;
   logic                 i_valid;
   logic [PM_WIDTH-1:0]  i_PM_0;
   logic [PM_WIDTH-1:0]  i_PM_1;
   logic [PM_WIDTH-1:0]  i_PM_2;
   logic [PM_WIDTH-1:0]  i_PM_3;
   logic [PM_WIDTH-1:0]  o_PM_0;
   logic [PM_WIDTH-1:0]  o_PM_1;
   logic [PM_WIDTH-1:0]  o_PM_2;
   logic [PM_WIDTH-1:0]  o_PM_3;
   logic                 o_busy;
   logic [1:0]           o_best_state;
   logic [PM_WIDTH-1:0]  o_best_PM;
   logic [CNT_WIDTH-1:0] o_step_cnt;
   logic                 o_frame_done;

   modport master (
      output i_start, i_valid, i_PM_0, i_PM_1, i_PM_2, i_PM_3,
      input  o_PM_0, o_PM_1, o_PM_2, o_PM_3,
      input  o_busy, o_best_state, o_best_PM, o_step_cnt, o_frame_done
   );

   modport slave (
      input  i_start, i_valid, i_PM_0, i_PM_1, i_PM_2, i_PM_3,
      output o_PM_0, o_PM_1, o_PM_2, o_PM_3,
      output o_busy, o_best_state, o_best_PM, o_step_cnt, o_frame_done
   );
endinterface
`default_nettype wire

// File: rtl/path_metric_register_unit.sv
`default_nettype none
// ============================================================================
// Module   : path_metric_register_unit
// Brief    : Normalized path-metric store, best-state tracker and frame
//            step counter closing the loop around the 4-state ACSU.
// Revision : 1.0 - initial release
// ============================================================================
module path_metric_register_unit #(
   parameter int PM_WIDTH  = 2,
   parameter int FRAME_LEN = 16,
   parameter int CNT_WIDTH = 5
) (
   input wire i_clk,
   input wire i_rst,
   path_metric_register_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [PM_WIDTH-1:0]  c_PM_MAX = {PM_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] c_LAST   = CNT_WIDTH'(FRAME_LEN - 1);

   state_t               r_state;
   state_t               w_nextState;
   logic [PM_WIDTH-1:0]  r_pm [4];
   logic [PM_WIDTH-1:0]  w_pmIn [4];
   logic [PM_WIDTH-1:0]  w_pmNorm [4];
   logic [PM_WIDTH-1:0]  w_min;
   logic [1:0]           w_minIdx;
   logic                 r_busy;
   logic [1:0]           r_bestState;
   logic [PM_WIDTH-1:0]  r_bestPm;
   logic [CNT_WIDTH-1:0] r_stepCnt;
   logic                 r_frameDone;
   logic                 w_accept;
   logic                 w_lastStep;

   assign w_pmIn[0] = bus.i_PM_0;
   assign w_pmIn[1] = bus.i_PM_1;
   assign w_pmIn[2] = bus.i_PM_2;
   assign w_pmIn[3] = bus.i_PM_3;

   // Strict less-than keeps the earliest index on ties.
   always_comb begin
      w_min    = w_pmIn[0];
      w_minIdx = 2'd0;
      for (int k = 1; k < 4; k++) begin
         if (w_pmIn[k] < w_min) begin
            w_min    = w_pmIn[k];
            w_minIdx = 2'(k);
         end
      end
   end

   generate
      for (genvar k = 0; k < 4; k++) begin : g_norm
         assign w_pmNorm[k] = w_pmIn[k] - w_min;
      end
   endgenerate

   assign w_accept   = (r_state == S_RUN) && bus.i_valid && !bus.i_start;
   assign w_lastStep = (r_stepCnt == c_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A start pulse restarts the frame from any state.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_nextState = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.i_start) begin
               w_nextState = S_RUN;
            end else if (w_accept && w_lastStep) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            w_nextState = bus.i_start ? S_RUN : S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pm[0]     <= '0;
         r_pm[1]     <= c_PM_MAX;
         r_pm[2]     <= c_PM_MAX;
         r_pm[3]     <= c_PM_MAX;
         r_busy      <= 1'b0;
         r_bestState <= 2'd0;
         r_bestPm    <= '0;
         r_stepCnt   <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_busy      <= (w_nextState == S_RUN);
         r_frameDone <= w_accept && w_lastStep;
         if (bus.i_start) begin
            r_pm[0]   <= '0;
            r_pm[1]   <= c_PM_MAX;
            r_pm[2]   <= c_PM_MAX;
            r_pm[3]   <= c_PM_MAX;
            r_stepCnt <= '0;
         end else if (w_accept) begin
            for (int k = 0; k < 4; k++) begin
               r_pm[k] <= w_pmNorm[k];
            end
            r_bestState <= w_minIdx;
            r_bestPm    <= w_min;
            r_stepCnt   <= r_stepCnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.o_PM_0       = r_pm[0];
   assign bus.o_PM_1       = r_pm[1];
   assign bus.o_PM_2       = r_pm[2];
   assign bus.o_PM_3       = r_pm[3];
   assign bus.o_busy       = r_busy;
   assign bus.o_best_state = r_bestState;
   assign bus.o_best_PM    = r_bestPm;
   assign bus.o_step_cnt   = r_stepCnt;
   assign bus.o_frame_done = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_path_metric_register_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_path_metric_register_unit
// Brief    : Randomized bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_path_metric_register_unit;
   localparam int PM_WIDTH  = 2;
   localparam int FRAME_LEN = 16;
   localparam int CNT_WIDTH = 5;
   localparam int PM_MAX    = (1 << PM_WIDTH) - 1;
   localparam int OBSW      = 4 * PM_WIDTH + 1 + 2 + PM_WIDTH + CNT_WIDTH + 1;
   localparam logic [OBSW-1:0] RST_OBS =
      {2'd0, 2'd3, 2'd3, 2'd3, 1'b0, 2'd0, 2'd0, 5'd0, 1'b0};

   logic i_clk = 1'b0;
   logic i_rst;
   always #5 i_clk = ~i_clk;

   path_metric_register_unit_if #(.PM_WIDTH(PM_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

   path_metric_register_unit #(
      .PM_WIDTH(PM_WIDTH), .FRAME_LEN(FRAME_LEN), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: a frame is "active" between start and its last step.
   int mPm [4];
   int mBest, mBestPm, mCnt;
   bit mActive, mDone;

   logic [OBSW-1:0] obs;
   assign obs = {bus.o_PM_0, bus.o_PM_1, bus.o_PM_2, bus.o_PM_3, bus.o_busy,
                 bus.o_best_state, bus.o_best_PM, bus.o_step_cnt, bus.o_frame_done};

   function automatic logic [OBSW-1:0] expected();
      return {PM_WIDTH'(mPm[0]), PM_WIDTH'(mPm[1]), PM_WIDTH'(mPm[2]), PM_WIDTH'(mPm[3]),
              mActive, 2'(mBest), PM_WIDTH'(mBestPm), CNT_WIDTH'(mCnt), mDone};
   endfunction

   task automatic model_step(input bit rst, input bit st, input bit vl, input int p [4]);
      int mn;
      if (rst) begin
         mPm = '{0, PM_MAX, PM_MAX, PM_MAX};
         mActive = 0; mBest = 0; mBestPm = 0; mCnt = 0; mDone = 0;
      end else if (st) begin
         mPm = '{0, PM_MAX, PM_MAX, PM_MAX};
         mCnt = 0; mActive = 1; mDone = 0;
      end else if (mActive && vl) begin
         mn = p[0];
         foreach (p[k]) if (p[k] < mn) mn = p[k];
         mBest = -1;
         foreach (p[k]) if (p[k] == mn && mBest < 0) mBest = k;
         foreach (p[k]) mPm[k] = p[k] - mn;
         mBestPm = mn;
         mCnt++;
         mDone = (mCnt == FRAME_LEN);
         if (mDone) mActive = 0;
      end else begin
         mDone = 0;
      end
   endtask

   task automatic cycle(input bit rst, input bit st, input bit vl,
                        input int p0, input int p1, input int p2, input int p3);
      int p [4];
      p = '{p0, p1, p2, p3};
      i_rst         = rst;
      bus.i_start   = st;
      bus.i_valid   = vl;
      bus.i_PM_0    = PM_WIDTH'(p0);
      bus.i_PM_1    = PM_WIDTH'(p1);
      bus.i_PM_2    = PM_WIDTH'(p2);
      bus.i_PM_3    = PM_WIDTH'(p3);
      @(posedge i_clk);
      model_step(rst, st, vl, p);
      #1;
   endtask

   function automatic int r4();
      return int'($urandom_range(0, PM_MAX));
   endfunction

   task automatic test_reset();
      cycle(1, 1, 1, r4(), r4(), r4(), r4());
      cycle(1, 1, 1, r4(), r4(), r4(), r4());
      checks++;
      if (obs !== RST_OBS) begin
         failures++;
         $display("FAIL reset got=%h exp=%h", obs, RST_OBS);
      end
   endtask

   task automatic test_basic();
      cycle(0, 1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_step_cnt !== 5'd0) begin
         failures++;
         $display("FAIL start_busy got=%h exp=%h", obs, expected());
      end
      cycle(0, 0, 1, 2, 1, 3, 1);
      checks++;
      if (obs !== {2'd1, 2'd0, 2'd2, 2'd0, 1'b1, 2'd1, 2'd1, 5'd1, 1'b0}) begin
         failures++;
         $display("FAIL first_step got=%h exp=%h", obs,
                  {2'd1, 2'd0, 2'd2, 2'd0, 1'b1, 2'd1, 2'd1, 5'd1, 1'b0});
      end
      cycle(0, 0, 1, 2, 2, 2, 2);
      checks++;
      if (obs !== {2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd2, 5'd2, 1'b0}) begin
         failures++;
         $display("FAIL tie_step got=%h exp=%h", obs,
                  {2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd2, 5'd2, 1'b0});
      end
      cycle(0, 0, 0, 3, 1, 0, 2);
      checks++;
      if (obs !== {2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd2, 5'd2, 1'b0}) begin
         failures++;
         $display("FAIL idle_hold got=%h exp=%h", obs, expected());
      end
   endtask

   task automatic test_frame();
      int acc = 0;
      int doneCnt = 0;
      logic [OBSW-1:0] snap;
      cycle(0, 1, 0, 0, 0, 0, 0);
      while (acc < FRAME_LEN) begin
         repeat ($urandom_range(0, 2)) begin
            cycle(0, 0, 0, r4(), r4(), r4(), r4());
            checks++;
            if (obs !== expected()) begin
               failures++;
               $display("FAIL frame_gap acc=%0d got=%h exp=%h", acc, obs, expected());
            end
            if (bus.o_frame_done === 1'b1) doneCnt++;
         end
         cycle(0, 0, 1, r4(), r4(), r4(), r4());
         acc++;
         checks++;
         if (obs !== expected()) begin
            failures++;
            $display("FAIL frame_step acc=%0d got=%h exp=%h", acc, obs, expected());
         end
         if (bus.o_frame_done === 1'b1) doneCnt++;
      end
      checks++;
      if (bus.o_frame_done !== 1'b1 || bus.o_step_cnt !== 5'd16 || doneCnt != 1) begin
         failures++;
         $display("FAIL frame_done done=%b cnt=%0d pulses=%0d exp done=1 cnt=16 pulses=1",
                  bus.o_frame_done, bus.o_step_cnt, doneCnt);
      end
      snap = obs;
      cycle(0, 0, 0, r4(), r4(), r4(), r4());
      checks++;
      if (bus.o_frame_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_step_cnt !== 5'd16) begin
         failures++;
         $display("FAIL after_done got=%h exp=%h", obs, expected());
      end
      cycle(0, 0, 1, 3, 0, 1, 2);
      checks++;
      if (obs !== {snap[OBSW-1:1], 1'b0}) begin
         failures++;
         $display("FAIL extra_valid got=%h exp=%h", obs, {snap[OBSW-1:1], 1'b0});
      end
   endtask

   task automatic test_restart();
      cycle(0, 1, 0, 0, 0, 0, 0);
      repeat (5) cycle(0, 0, 1, r4(), r4(), r4(), r4());
      checks++;
      if (bus.o_step_cnt !== 5'd5 || obs !== expected()) begin
         failures++;
         $display("FAIL pre_restart got=%h exp=%h", obs, expected());
      end
      cycle(0, 1, 1, 3, 2, 1, 0);
      checks++;
      if (obs[OBSW-1:OBSW-8] !== 8'b00_11_11_11 || bus.o_step_cnt !== 5'd0 ||
          bus.o_frame_done !== 1'b0 || bus.o_busy !== 1'b1) begin
         failures++;
         $display("FAIL restart got=%h exp=%h", obs, expected());
      end
      for (int i = 1; i <= FRAME_LEN; i++) begin
         cycle(0, 0, 1, r4(), r4(), r4(), r4());
         checks++;
         if (obs !== expected() || bus.o_frame_done !== (i == FRAME_LEN)) begin
            failures++;
            $display("FAIL restart_frame i=%0d got=%h exp=%h", i, obs, expected());
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(0, 1, 0, 0, 0, 0, 0);
      repeat (9) cycle(0, 0, 1, r4(), r4(), r4(), r4());
      checks++;
      if (bus.o_step_cnt !== 5'd9) begin
         failures++;
         $display("FAIL mid_cnt got=%0d exp=9", bus.o_step_cnt);
      end
      cycle(1, 0, 1, r4(), r4(), r4(), r4());
      checks++;
      if (obs !== RST_OBS) begin
         failures++;
         $display("FAIL mid_reset got=%h exp=%h", obs, RST_OBS);
      end
      repeat (3) begin
         cycle(0, 0, 1, 2, 1, 3, 1);
         checks++;
         if (obs !== RST_OBS) begin
            failures++;
            $display("FAIL idle_ignore got=%h exp=%h", obs, RST_OBS);
         end
      end
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 1, 3, 2, 1);
      checks++;
      if (obs !== expected()) begin
         failures++;
         $display("FAIL post_reset got=%h exp=%h", obs, expected());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
               $urandom_range(0, 99) < 60, r4(), r4(), r4(), r4());
         checks++;
         if (obs !== expected()) begin
            failures++;
            $display("FAIL random i=%0d got=%h exp=%h", i, obs, expected());
         end
      end
   endtask

   initial begin
      i_rst       = 1'b1;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_PM_0  = '0;
      bus.i_PM_1  = '0;
      bus.i_PM_2  = '0;
      bus.i_PM_3  = '0;
      test_reset();
      test_basic();
      test_frame();
      test_restart();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
